// File: rtl/kws_layer_sequencer.sv
// Sequences NUM_LAYERS accelerator layers per MFCC feature vector and owns the shared PSRAM pad bus.
// Only the layer in LAUNCH/RUN may drive the pads; everything else sees an idle bus.
module kws_layer_sequencer #(
    parameter int NUM_LAYERS     = 6,
    parameter int LW             = 3,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TO_BITS        = 21,
    parameter int CNT_BITS       = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    cont_mode,
    input  logic [NUM_LAYERS-1:0]   bypass_mask,
    input  logic                    feat_valid,
    output logic [NUM_LAYERS-1:0]   layer_start,
    input  logic [NUM_LAYERS-1:0]   layer_done,
    input  logic [NUM_LAYERS-1:0]   lyr_psram_sck,
    input  logic [NUM_LAYERS-1:0]   lyr_psram_ce_n,
    input  logic [4*NUM_LAYERS-1:0] lyr_psram_douten,
    input  logic [4*NUM_LAYERS-1:0] lyr_psram_dout,
    output logic                    psram_sck,
    output logic                    psram_ce_n,
    output logic [3:0]              psram_douten,
    output logic [3:0]              psram_dout,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [LW-1:0]           err_layer,
    output logic [LW-1:0]           cur_layer,
    output logic [CNT_BITS-1:0]     run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_FEAT, S_LAUNCH, S_RUN, S_NEXT, S_FINISH, S_ERROR
    } state_t;

    localparam logic [TO_BITS-1:0] WD_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);

    state_t                state_q;
    logic [NUM_LAYERS-1:0] mask_q;
    logic                  cont_q;
    logic [LW-1:0]         cur_q;
    logic [LW-1:0]         err_layer_q;
    logic [TO_BITS-1:0]    wd_q;
    logic [CNT_BITS-1:0]   cnt_q;
    logic [CNT_BITS-1:0]   run_cycles_q;

    int   first_idx;
    int   next_idx;
    logic cur_done;

    // Lowest non-bypassed layer index >= from, or -1 when none remains.
    function automatic int find_from(input logic [NUM_LAYERS-1:0] m, input int from);
        int r;
        r = -1;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (i >= from && !m[i]) r = i;
        end
        return r;
    endfunction

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        first_idx = find_from(mask_q, 0);
        next_idx  = find_from(mask_q, int'(cur_q) + 1);
        cur_done  = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (i == int'(cur_q)) cur_done = layer_done[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            cont_q       <= 1'b0;
            cur_q        <= '0;
            err_layer_q  <= '0;
            wd_q         <= '0;
            cnt_q        <= '0;
            run_cycles_q <= '0;
        end else if (abort) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        state_q <= S_WAIT_FEAT;
                        mask_q  <= bypass_mask;
                        cont_q  <= cont_mode;
                    end
                end
                S_WAIT_FEAT: begin
                    if (feat_valid) begin
                        cnt_q <= '0;
                        if (first_idx < 0) begin
                            state_q <= S_FINISH;
                        end else begin
                            cur_q   <= LW'(first_idx);
                            state_q <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    wd_q    <= '0;
                    cnt_q   <= sat_inc(cnt_q);
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    cnt_q <= sat_inc(cnt_q);
                    // A done arriving on the last watchdog cycle still counts as success.
                    if (cur_done) begin
                        state_q <= S_NEXT;
                    end else if (wd_q == WD_LAST) begin
                        state_q     <= S_ERROR;
                        err_layer_q <= cur_q;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_NEXT: begin
                    cnt_q <= sat_inc(cnt_q);
                    if (next_idx < 0) begin
                        state_q <= S_FINISH;
                    end else begin
                        cur_q   <= LW'(next_idx);
                        state_q <= S_LAUNCH;
                    end
                end
                S_FINISH: begin
                    run_cycles_q <= cnt_q;
                    state_q      <= cont_q ? S_WAIT_FEAT : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Abort suppresses the start/done pulses of the very cycle it is raised.
    always_comb begin
        layer_start = '0;
        if (state_q == S_LAUNCH && !abort) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (i == int'(cur_q)) layer_start[i] = 1'b1;
            end
        end
    end

    always_comb begin
        psram_sck    = 1'b0;
        psram_ce_n   = 1'b1;
        psram_douten = 4'h0;
        psram_dout   = 4'h0;
        if (state_q == S_LAUNCH || state_q == S_RUN) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (i == int'(cur_q)) begin
                    psram_sck    = lyr_psram_sck[i];
                    psram_ce_n   = lyr_psram_ce_n[i];
                    psram_douten = lyr_psram_douten[4*i +: 4];
                    psram_dout   = lyr_psram_dout[4*i +: 4];
                end
            end
        end
    end

    assign busy       = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign error      = (state_q == S_ERROR);
    assign done       = (state_q == S_FINISH) && !abort;
    assign err_layer  = err_layer_q;
    assign cur_layer  = cur_q;
    assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_kws_layer_sequencer.sv
// Scoreboard bench for kws_layer_sequencer: a schedule model predicts start/done/error events and the pad owner per cycle.
module tb_kws_layer_sequencer;
    localparam int NL   = 6;
    localparam int LW   = 3;
    localparam int TO   = 16;
    localparam int TOB  = 5;
    localparam int CB   = 6;
    localparam int CMAX = (1 << CB) - 1;
    localparam int MAXC = 20000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, cont_mode, feat_valid;
    logic [NL-1:0] bypass_mask, layer_start, layer_done, lyr_psram_sck, lyr_psram_ce_n;
    logic [4*NL-1:0] lyr_psram_douten, lyr_psram_dout;
    logic          psram_sck, psram_ce_n, busy, done, error;
    logic [3:0]    psram_douten, psram_dout;
    logic [LW-1:0] err_layer, cur_layer;
    logic [CB-1:0] run_cycles;

    kws_layer_sequencer #(.NUM_LAYERS(NL), .LW(LW), .TIMEOUT_CYCLES(TO), .TO_BITS(TOB), .CNT_BITS(CB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont_mode(cont_mode),
        .bypass_mask(bypass_mask), .feat_valid(feat_valid), .layer_start(layer_start),
        .layer_done(layer_done), .lyr_psram_sck(lyr_psram_sck), .lyr_psram_ce_n(lyr_psram_ce_n),
        .lyr_psram_douten(lyr_psram_douten), .lyr_psram_dout(lyr_psram_dout),
        .psram_sck(psram_sck), .psram_ce_n(psram_ce_n), .psram_douten(psram_douten),
        .psram_dout(psram_dout), .busy(busy), .done(done), .error(error),
        .err_layer(err_layer), .cur_layer(cur_layer), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; int layer; int cyc; int val; } ev_t;  // kind 0 start, 1 done, 2 error
    ev_t evq[$];

    int            checks = 0;
    int            errors = 0;
    int            exp_sel[MAXC];
    int            lat[NL];
    logic [NL-1:0] cur_mask;
    bit            t6 = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    function automatic void push(input int k, input int l, input int c, input int v);
        ev_t e;
        e.kind = k; e.layer = l; e.cyc = c; e.val = v;
        evq.push_back(e);
    endfunction

    function automatic void fill(input int a, input int b, input int l);
        for (int c = a; c <= b; c++) if (c < MAXC) exp_sel[c] = l;
    endfunction

    task automatic check_reset_state(input string name);
        chk({name, "_busy"}, 64'(busy), 64'(0));
        chk({name, "_outs"}, 64'({done, error, err_layer, cur_layer, run_cycles, layer_start}), 64'(0));
        chk({name, "_pad"}, 64'({psram_sck, psram_ce_n, psram_douten, psram_dout}), 64'(10'b0_1_0000_0000));
    endtask

    task automatic set_lats();
        for (int i = 0; i < NL; i++) lat[i] = $urandom_range(1, 16);
    endtask

    task automatic monitor();
        ev_t e;
        int c, sel, rc_cyc, rc_exp;
        logic [9:0] ep;
        logic [NL-1:0] oh;
        bit prev_err;
        rc_cyc = -1; rc_exp = 0; prev_err = 1'b0;
        forever begin
            @(negedge clk);
            c = cyc;
            sel = (c < MAXC) ? exp_sel[c] : -1;
            if (sel >= 0) begin
                ep = {lyr_psram_sck[sel], lyr_psram_ce_n[sel], lyr_psram_douten[4*sel +: 4], lyr_psram_dout[4*sel +: 4]};
                chk("cur_layer", 64'(cur_layer), 64'(sel));
                chk("busy_active", 64'(busy), 64'(1));
            end else begin
                ep = 10'b0_1_0000_0000;
            end
            chk("pad", 64'({psram_sck, psram_ce_n, psram_douten, psram_dout}), 64'(ep));
            if (layer_start != '0) begin
                if (evq.size() == 0) chk("unexpected_start", 64'(layer_start), 64'(0));
                else begin
                    e = evq.pop_front();
                    oh = '0; oh[e.layer] = 1'b1;
                    chk("start_kind", 64'(0), 64'(e.kind));
                    chk("start_layer", 64'(layer_start), 64'(oh));
                    chk("start_cycle", 64'(c), 64'(e.cyc));
                end
            end
            if (done) begin
                if (evq.size() == 0) chk("unexpected_done", 64'(done), 64'(0));
                else begin
                    e = evq.pop_front();
                    chk("done_kind", 64'(1), 64'(e.kind));
                    chk("done_cycle", 64'(c), 64'(e.cyc));
                    rc_cyc = c + 1; rc_exp = e.val;
                end
            end
            if (c == rc_cyc) chk("run_cycles", 64'(run_cycles), 64'(rc_exp));
            if (error && !prev_err) begin
                if (evq.size() == 0) chk("unexpected_error", 64'(error), 64'(0));
                else begin
                    e = evq.pop_front();
                    chk("err_kind", 64'(2), 64'(e.kind));
                    chk("err_layer", 64'(err_layer), 64'(e.layer));
                    chk("err_cycle", 64'(c), 64'(e.cyc));
                end
            end
            prev_err = error;
        end
    endtask

    // Layer models: done k=lat cycles after their start, plus stray done pulses from idle layers.
    task automatic responder();
        int pend[NL];
        int active, j;
        active = -1;
        for (int i = 0; i < NL; i++) pend[i] = -1;
        forever begin
            @(posedge clk); #2;
            layer_done = '0;
            for (int i = 0; i < NL; i++) begin
                if (layer_start[i]) begin
                    active = i;
                    pend[i] = (lat[i] > 0) ? cyc + lat[i] : -1;
                end
            end
            for (int i = 0; i < NL; i++) begin
                if (pend[i] == cyc) begin
                    layer_done[i] = 1'b1; pend[i] = -1;
                    if (active == i) active = -1;
                end
            end
            if (active >= 0 && $urandom_range(0, 3) == 0) begin
                j = $urandom_range(0, NL - 1);
                if (j != active) layer_done[j] = 1'b1;
            end
            lyr_psram_sck = NL'($urandom);
            if (t6) begin
                lyr_psram_ce_n = '0;
                for (int i = 0; i < NL; i++) begin
                    lyr_psram_douten[4*i +: 4] = (i == 1) ? 4'hF : 4'h0;
                    lyr_psram_dout[4*i +: 4]   = (i == 1) ? 4'hA : 4'h5;
                end
            end else begin
                lyr_psram_ce_n   = NL'($urandom);
                lyr_psram_douten = (4*NL)'($urandom);
                lyr_psram_dout   = (4*NL)'($urandom);
            end
        end
    endtask

    task automatic do_start(input logic [NL-1:0] m, input bit cont);
        @(posedge clk); #1;
        start = 1'b1; bypass_mask = m; cont_mode = cont; cur_mask = m;
        @(posedge clk); #1;
        start = 1'b0; bypass_mask = NL'($urandom); cont_mode = 1'($urandom);
    endtask

    task automatic do_abort();
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_idle", 64'({busy, error, done}), 64'(0));
    endtask

    // kind 0: plain run; 1: abort 'off' cycles after layer tgt launches; 2: async reset likewise.
    task automatic do_run(input int kind, input int tgt, input int off);
        int t, rc, a, endc;
        bit stop;
        feat_valid = 1'b1;
        t = cyc + 1; rc = 0; a = -1; stop = 1'b0; endc = 0;
        for (int i = 0; i < NL; i++) begin
            if (!cur_mask[i] && !stop) begin
                if (kind != 0 && i == tgt) begin
                    a = t + off; stop = 1'b1; endc = a + 3;
                    if (kind == 1) begin
                        if (off > 0) push(0, i, t, 0);
                        fill(t, a, i);
                    end else begin
                        push(0, i, t, 0);
                        fill(t, a - 1, i);
                    end
                end else begin
                    push(0, i, t, 0);
                    if (lat[i] == 0) begin
                        fill(t, t + TO, i);
                        push(2, i, t + TO + 1, 0);
                        stop = 1'b1; endc = t + TO + 3;
                    end else begin
                        fill(t, t + lat[i], i);
                        t += lat[i] + 2;
                        rc += lat[i] + 2;
                    end
                end
            end
        end
        if (!stop) begin
            push(1, 0, t, (rc > CMAX) ? CMAX : rc);
            endc = t + 2;
        end
        if (endc >= MAXC - 4) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", endc, MAXC);
            $fatal(1);
        end
        while (cyc < endc) begin
            @(posedge clk); #1;
            feat_valid = 1'b0; start = 1'b0; abort = 1'b0;
            if (kind == 1 && cyc == a) abort = 1'b1;
            else if ((a < 0 || cyc < a) && exp_sel[cyc] >= 0 && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) start = 1'b1;
                else feat_valid = 1'b1;
            end
            if (kind == 2 && cyc == a) begin
                #2 rst_n = 1'b0;
                #1 check_reset_state("midrun_reset");
            end
            if (kind == 2 && cyc == a + 2) rst_n = 1'b1;
        end
    endtask

    initial begin
        logic [NL-1:0] m;
        int k, tgt;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cont_mode = 1'b0; feat_valid = 1'b0;
        bypass_mask = '0; layer_done = '0; lyr_psram_sck = '0; lyr_psram_ce_n = '1;
        lyr_psram_douten = '0; lyr_psram_dout = '0; cur_mask = '0;
        for (int i = 0; i < MAXC; i++) exp_sel[i] = -1;
        for (int i = 0; i < NL; i++) lat[i] = 10;
        fork
            monitor();
            responder();
        join_none
        #1 check_reset_state("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // six layers, fixed latency 10 (72 cycles saturates the 6-bit counter)
        do_start('0, 1'b0); do_run(0, 0, 0);
        chk("t1_idle", 64'(busy), 64'(0));
        do_start(6'b000110, 1'b0); do_run(0, 0, 0);

        lat[2] = 0;
        do_start('0, 1'b0); do_run(0, 0, 0);
        chk("t3_error", 64'({error, busy, err_layer, psram_ce_n}), 64'({1'b1, 1'b0, 3'd2, 1'b1}));

        set_lats(); lat[0] = 16;
        do_start(6'b001000, 1'b0);
        chk("err_restart", 64'({error, busy}), 64'(2'b01));
        do_run(0, 0, 0);

        set_lats(); lat[3] = 14;
        do_start('0, 1'b0); do_run(1, 3, 5);
        chk("t4_abort", 64'({busy, done, psram_ce_n}), 64'(3'b001));
        set_lats(); do_start('0, 1'b0); do_run(0, 0, 0);

        set_lats(); do_start(6'b000001, 1'b0); do_run(1, 2, 0);
        chk("abort_launch", 64'(busy), 64'(0));

        set_lats(); do_start(6'b100100, 1'b1); do_run(0, 0, 0);
        chk("t5_busy1", 64'(busy), 64'(1));
        set_lats(); do_run(0, 0, 0);
        chk("t5_busy2", 64'(busy), 64'(1));
        do_abort();

        do_start(6'h3F, 1'b0); do_run(0, 0, 0);

        t6 = 1'b1; set_lats(); lat[2] = 14;
        do_start('0, 1'b0); do_run(2, 2, 4);
        t6 = 1'b0;
        chk("after_reset", 64'(busy), 64'(0));

        for (int it = 0; it < 24; it++) begin
            m = NL'($urandom);
            if ($urandom_range(0, 3) == 0) m = '0;
            set_lats();
            k = $urandom_range(0, 5);
            tgt = $urandom_range(0, NL - 1);
            if (k >= 4) m[tgt] = 1'b0;
            if (k == 4) begin
                lat[tgt] = 14;
                do_start(m, 1'($urandom)); do_run(1, tgt, $urandom_range(0, 12));
            end else if (k == 5) begin
                lat[tgt] = 0;
                do_start(m, 1'($urandom)); do_run(0, 0, 0);
                chk("rand_error", 64'({error, busy}), 64'(2'b10));
            end else begin
                do_start(m, k[0]); do_run(0, 0, 0);
                if (k[0]) begin
                    chk("rand_cont_busy", 64'(busy), 64'(1));
                    set_lats(); do_run(0, 0, 0);
                    do_abort();
                end
            end
        end

        repeat (5) @(posedge clk);
        #1 chk("queue_empty", 64'(evq.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
